convolution_engine: RTL and testbench

CONVOLUTION_ENGINE -- requirements
Module: convolution

---
 rtl/convolution_engine.sv | 180 ++++++++++++++++++
 tb/tb_convolution_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/convolution_engine.sv
// Convolution engine: 3x3 Sobel-x kernel slid over a fixed 8x8 ramp image.
// The 36 results land in a write-only result RAM; done goes high once the
// last pixel is stored and stays high until reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | first run edge: clear accumulator, row, col and tap index
// MAC   | one multiply-accumulate per edge, taps 0..8
// STORE | write the accumulator to RAM[6*row+col], advance the pixel
// DONE  | terminal; done held high, no further RAM writes
module convolution_engine (
  input  logic clk,
  input  logic rst,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'd8;
  localparam logic [2:0] LAST_IDX = 3'd5;

  state_t state;
  state_t state_next;

  logic [2:0]         row;
  logic [2:0]         col;
  logic [3:0]         tap;
  logic signed [19:0] acc;

  // Result RAM, write-only from the datapath; observed hierarchically.
  logic signed [19:0] result_ram [0:35];

  // FSM control strobes
  logic ctl_init;
  logic ctl_mac;
  logic ram_we;
  logic last_pixel;

  // Tap decode and ROM outputs
  logic [1:0]         tap_m;
  logic [1:0]         tap_n;
  logic [2:0]         pix_row;
  logic [2:0]         pix_col;
  logic [5:0]         pix_addr;
  logic signed [7:0]  pixel;
  logic signed [7:0]  coef;
  logic signed [15:0] prod;
  logic [5:0]         ram_addr;

  assign last_pixel = (row == LAST_IDX) && (col == LAST_IDX);

  // Split the tap index into kernel row/column without a divider.
  always_comb begin
    tap_m = 2'd0;
    tap_n = 2'd0;
    case (tap)
      4'd0: begin tap_m = 2'd0; tap_n = 2'd0; end
      4'd1: begin tap_m = 2'd0; tap_n = 2'd1; end
      4'd2: begin tap_m = 2'd0; tap_n = 2'd2; end
      4'd3: begin tap_m = 2'd1; tap_n = 2'd0; end
      4'd4: begin tap_m = 2'd1; tap_n = 2'd1; end
      4'd5: begin tap_m = 2'd1; tap_n = 2'd2; end
      4'd6: begin tap_m = 2'd2; tap_n = 2'd0; end
      4'd7: begin tap_m = 2'd2; tap_n = 2'd1; end
      4'd8: begin tap_m = 2'd2; tap_n = 2'd2; end
      default: begin tap_m = 2'd0; tap_n = 2'd0; end
    endcase
  end

  // Row/col never exceed 5 and m/n never exceed 2, so the sums fit in
  // three bits and the image address never leaves 0..63.
  assign pix_row  = row + {1'b0, tap_m};
  assign pix_col  = col + {1'b0, tap_n};
  assign pix_addr = {pix_row, pix_col};

  // Image ROM: pixel(r,c) = 8*r + c, which is exactly the 6-bit address.
  assign pixel = signed'({2'b00, pix_addr});

  // Kernel ROM: Sobel-x, row-major, no flip.
  always_comb begin
    coef = 8'sd0;
    case (tap)
      4'd0: coef =  8'sd1;
      4'd1: coef =  8'sd0;
      4'd2: coef = -8'sd1;
      4'd3: coef =  8'sd2;
      4'd4: coef =  8'sd0;
      4'd5: coef = -8'sd2;
      4'd6: coef =  8'sd1;
      4'd7: coef =  8'sd0;
      4'd8: coef = -8'sd1;
      default: coef = 8'sd0;
    endcase
  end

  assign prod     = pixel * coef;
  assign ram_addr = ({3'b000, row} * 6'd6) + {3'b000, col};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    ctl_init   = 1'b0;
    ctl_mac    = 1'b0;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        ctl_init   = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        ctl_mac = 1'b1;
        if (tap == LAST_TAP) begin
          state_next = STORE;
        end
      end
      STORE: begin
        ram_we     = 1'b1;
        state_next = last_pixel ? DONE : MAC;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulator, tap counter, pixel position and sticky done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= '0;
      tap  <= '0;
      row  <= '0;
      col  <= '0;
      done <= 1'b0;
    end else if (ctl_init) begin
      acc <= '0;
      tap <= '0;
      row <= '0;
      col <= '0;
    end else if (ctl_mac) begin
      acc <= acc + {{4{prod[15]}}, prod};
      tap <= tap + 4'd1;
    end else if (ram_we) begin
      acc <= '0;
      tap <= '0;
      if (last_pixel) begin
        done <= 1'b1;
      end else if (col == LAST_IDX) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  // Result RAM write port; contents survive reset, reset blocks the write.
  always_ff @(posedge clk) begin
    if (rst && ram_we) begin
      result_ram[ram_addr] <= acc;
    end
  end

endmodule

// File: tb/tb_convolution_engine.sv
// Bench for convolution_engine: reference convolution computed with plain
// loops, done timing tracked as an edge count since reset release, and
// reset injected at fixed and randomly chosen points.
module tb_convolution_engine;

  logic clk;
  logic rst;
  logic done;

  int checks;
  int errors;

  int run_edges;   // rising edges seen with rst high since last reset edge
  int wr_run;      // RAM writes since last reset edge
  int wr_total;    // RAM writes over the whole simulation

  int exp_out [0:35];
  int exp_acc [0:8];

  convolution_engine dut (
    .clk  (clk),
    .rst  (rst),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-level bookkeeping for the reference model.
  always @(posedge clk) begin
    if (!rst) begin
      run_edges = 0;
      wr_run    = 0;
    end else begin
      run_edges = run_edges + 1;
      if (dut.ram_we) begin
        wr_run   = wr_run + 1;
        wr_total = wr_total + 1;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int kern(input int m, input int n);
    int k [0:8];
    k = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    return k[3*m + n];
  endfunction

  function automatic int pix(input int r, input int c);
    return 8*r + c;
  endfunction

  // Advance n cycles, checking done against the edge-count model each cycle.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("done", int'(done), (run_edges >= 361) ? 1 : 0);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 36; a++) begin
      chk(tag, int'(dut.result_ram[a]), exp_out[a]);
    end
  endtask

  initial begin
    int acc_sum;
    int pre_total;
    int hit;
    int hold;

    checks    = 0;
    errors    = 0;
    run_edges = 0;
    wr_run    = 0;
    wr_total  = 0;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        acc_sum = 0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            acc_sum += kern(m, n) * pix(i + m, j + n);
        exp_out[6*i + j] = acc_sum;
      end
    end
    acc_sum = 0;
    for (int t = 0; t < 9; t++) begin
      acc_sum += kern(t / 3, t % 3) * pix(t / 3, t % 3);
      exp_acc[t] = acc_sum;
    end

    // Reset state
    rst = 1'b0;
    ticks(1);
    chk("rst_acc", int'(dut.acc), 0);
    chk("rst_state_idle", int'(dut.state), 0);

    // Full first run with accumulator probe on pixel (0,0)
    rst = 1'b1;
    ticks(1);
    for (int t = 0; t < 9; t++) begin
      ticks(1);
      chk("acc_probe", int'(dut.acc), exp_acc[t]);
    end
    ticks(1);
    chk("ram0_first", int'(dut.result_ram[0]), exp_out[0]);
    ticks(361 - 11 - 1);
    chk("done_pre361", int'(done), 0);
    ticks(1);
    chk("done_at361", int'(done), 1);
    ticks(100);
    chk("writes_run1", wr_run, 36);
    check_ram("ram_run1");

    // Reset mid-operation at edge 150 after release
    rst = 1'b0;
    ticks(1);
    rst = 1'b1;
    ticks(149);
    rst = 1'b0;
    ticks(1);
    chk("done_midrst", int'(done), 0);
    rst = 1'b1;
    ticks(361);
    chk("done_after_midrst", int'(done), 1);
    chk("writes_run2", wr_run, 36);
    check_ram("ram_run2");

    // Reset while in DONE
    ticks(5);
    rst = 1'b0;
    ticks(1);
    chk("done_clr_from_done", int'(done), 0);
    rst = 1'b1;
    ticks(360);
    chk("done_rerun_360", int'(done), 0);
    ticks(1);
    chk("done_rerun_361", int'(done), 1);
    ticks(10);

    // Randomized reset injection points and hold lengths
    for (int it = 0; it < 4; it++) begin
      rst = 1'b0;
      ticks(1);
      rst = 1'b1;
      hit  = $urandom_range(1, 360);
      hold = $urandom_range(1, 5);
      ticks(hit);
      rst = 1'b0;
      ticks(hold);
      rst = 1'b1;
      ticks(361 + $urandom_range(0, 20));
      chk("writes_rand", wr_run, 36);
      check_ram("ram_rand");
    end

    // Long reset hold: done stays low and nothing is written
    pre_total = wr_total;
    rst = 1'b0;
    ticks(500);
    chk("no_writes_in_rst", wr_total, pre_total);
    chk("done_long_rst", int'(done), 0);
    rst = 1'b1;
    ticks(361);
    chk("done_after_long_rst", int'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
